arb_protocol_monitor: RTL

Parametrised, synthesizable protocol monitor for an N-requester request/grant arbiter. It sits passively beside the arbiter on the arbitration interface and tracks each requester's request-to-grant life cycle. It reports per-requester grant counts, the worst observed grant latency, and sticky protocol-violation flags. It drives nothing back into the arbiter.

---
 rtl/arb_mon_pkg.sv | 24 ++
 rtl/arb_protocol_monitor_if.sv | 11 +
 rtl/arb_mon_chan.sv | 110 +++++++++++
 rtl/arb_protocol_monitor.sv | 76 +++++++
 4 files changed

// File: rtl/arb_mon_pkg.sv
// Shared types and helpers for the arbiter protocol monitor.
package arb_mon_pkg;

  // Per-requester life-cycle state.
  typedef enum logic [1:0] {
    IDLE,
    WAITING,
    GRANTED
  } arb_st_e;

  // Widest grant vector the popcount helper accepts; callers zero-extend.
  localparam int MAX_REQ = 32;

  // Number of bits set in a (zero-extended) grant vector.
  function automatic int unsigned popcount(input logic [MAX_REQ-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/arb_protocol_monitor_if.sv
// Request/grant arbitration bus observed by the monitor.
interface arb_protocol_monitor_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] grant;

  // The arbiter side drives both vectors; the monitor only listens.
  modport master (output request, output grant);
  modport slave  (input  request, input  grant);
endinterface

// File: rtl/arb_mon_chan.sv
// One requester's life-cycle tracker: FSM, wait counter, grant counter and
// sticky per-channel protocol flags. Offers a latency record to the top level
// on every edge where a grant starts.
module arb_mon_chan
  import arb_mon_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16,
  parameter int LAT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             req,
  input  logic             gnt,
  output logic [CNT_W-1:0] grant_cnt,
  output logic             rec_valid,
  output logic [LAT_W-1:0] rec_lat,
  output logic             err_spurious,
  output logic             err_drop,
  output logic             err_starve
);

  localparam logic [LAT_W-1:0] WAIT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] WAIT_MAX = LAT_W'(MAX_WAIT);
  // With a threshold of one, simply entering WAITING already starves.
  localparam bit ENTRY_STARVES = (MAX_WAIT == 1);

  arb_st_e          state;
  logic [LAT_W-1:0] wcnt;
  logic             ev_start;
  logic             ev_spur;
  logic             ev_drop;
  logic             ev_starve;
  logic             enter_wait;

  // Decode this edge's events from the current state and sampled inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ev_start   = 1'b0;
    ev_spur    = 1'b0;
    ev_drop    = 1'b0;
    ev_starve  = 1'b0;
    enter_wait = 1'b0;
    rec_lat    = '0;
    unique case (state)
      IDLE: begin
        ev_start   = req && gnt;
        ev_spur    = !req && gnt;
        enter_wait = req && !gnt;
      end
      WAITING: begin
        ev_start  = gnt;
        rec_lat   = wcnt;
        ev_drop   = !req && !gnt;
        ev_starve = req && !gnt && (wcnt == WAIT_MAX - WAIT_ONE);
      end
      GRANTED: begin
        ev_spur    = gnt && !req;
        enter_wait = req && !gnt;
      end
      default: ;
    endcase
    if (ENTRY_STARVES && enter_wait) ev_starve = 1'b1;
    rec_valid = ev_start;
  end

  // FSM and wait counter advance regardless of clear; statistics obey clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) begin
      state        <= IDLE;
      wcnt         <= '0;
      grant_cnt    <= '0;
      err_spurious <= 1'b0;
      err_drop     <= 1'b0;
      err_starve   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) state <= gnt ? GRANTED : WAITING;
          if (enter_wait) wcnt <= WAIT_ONE;
        end
        WAITING: begin
          if (gnt)                   state <= GRANTED;
          else if (!req)             state <= IDLE;
          else if (wcnt != WAIT_MAX) wcnt  <= wcnt + WAIT_ONE;
        end
        GRANTED: begin
          if (!gnt) state <= req ? WAITING : IDLE;
          if (enter_wait) wcnt <= WAIT_ONE;
        end
        default: state <= IDLE;
      endcase

      if (clear) begin
        grant_cnt    <= '0;
        err_spurious <= 1'b0;
        err_drop     <= 1'b0;
        err_starve   <= 1'b0;
      end else begin
        if (ev_start && (grant_cnt != '1)) grant_cnt <= grant_cnt + CNT_W'(1);
        if (ev_spur)   err_spurious <= 1'b1;
        if (ev_drop)   err_drop     <= 1'b1;
        if (ev_starve) err_starve   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_protocol_monitor.sv
// Passive monitor for an N-requester request/grant arbiter: per-requester
// grant counts, worst request-to-grant latency and sticky violation flags.
module arb_protocol_monitor
  import arb_mon_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_WAIT = 16,
  parameter  int CNT_W    = 16,
  localparam int LAT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  arb_protocol_monitor_if.slave    bus,
  input  logic                     clear,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
  output logic [LAT_W-1:0]         max_lat,
  output logic                     err_multi,
  output logic [NUM_REQ-1:0]       err_spurious,
  output logic [NUM_REQ-1:0]       err_drop,
  output logic [NUM_REQ-1:0]       err_starve,
  output logic                     err_any
);

  logic [NUM_REQ-1:0] rec_valid;
  logic [LAT_W-1:0]   rec_lat [NUM_REQ];
  logic [LAT_W-1:0]   lat_best;
  logic               multi_now;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
    arb_mon_chan #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W),
      .LAT_W    (LAT_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .req          (bus.request[gi]),
      .gnt          (bus.grant[gi]),
      .grant_cnt    (grant_cnt[gi*CNT_W +: CNT_W]),
      .rec_valid    (rec_valid[gi]),
      .rec_lat      (rec_lat[gi]),
      .err_spurious (err_spurious[gi]),
      .err_drop     (err_drop[gi]),
      .err_starve   (err_starve[gi])
    );
  end

  // Largest latency recorded by any channel on this edge, plus overlap check.
  always_comb begin
    lat_best = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rec_valid[i] && (rec_lat[i] > lat_best)) lat_best = rec_lat[i];
    end
    // NUM_REQ must not exceed MAX_REQ for the zero-extension to be lossless.
    multi_now = popcount(MAX_REQ'(bus.grant)) > 1;
  end

  // Global statistics; err_any lags the flags it summarises by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_lat   <= '0;
      err_multi <= 1'b0;
      err_any   <= 1'b0;
    end else if (clear) begin
      max_lat   <= '0;
      err_multi <= 1'b0;
      err_any   <= 1'b0;
    end else begin
      if (lat_best > max_lat) max_lat <= lat_best;
      if (multi_now) err_multi <= 1'b1;
      err_any <= err_multi | (|err_spurious) | (|err_drop) | (|err_starve);
    end
  end

endmodule
